// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - commit, read and issue signals of the register file scoreboard
interface regfile_scoreboard_if #(
  parameter int NREAD = 4
);
  logic [5:0]          write_rn;
  logic [63:0]         write_data;
  logic [6*NREAD-1:0]  rd_addr;
  logic [64*NREAD-1:0] rd_data;
  logic                issue_valid;
  logic [6*NREAD-1:0]  issue_rs;
  logic [5:0]          issue_rd1;
  logic [5:0]          issue_rd2;
  logic                issue_stall;
  logic                issue_fire;
  logic                flush;
  logic [63:0]         busy_vec;

  modport master (
    output write_rn, write_data, rd_addr, issue_valid, issue_rs,
           issue_rd1, issue_rd2, flush,
    input  rd_data, issue_stall, issue_fire, busy_vec
  );

  modport slave (
    input  write_rn, write_data, rd_addr, issue_valid, issue_rs,
           issue_rd1, issue_rd2, flush,
    output rd_data, issue_stall, issue_fire, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 64x64 register file with per-register busy scoreboard and issue hazard stall
// Optional REGFILE_BYPASS_EN: same-cycle commit write-through to reads and to the stall check.
module regfile_scoreboard #(
  parameter int          NREAD       = 4,
  parameter logic [63:0] RESET_VALUE = 64'h0
) (
  input  logic                clk,
  input  logic                rst,
  regfile_scoreboard_if.slave bus
);

  if (NREAD < 1 || NREAD > 8) begin : g_nread_check
    $error("regfile_scoreboard: NREAD must be in 1..8");
  end

  // One-hot of a register number; r0 never participates in the scoreboard.
  function automatic logic [63:0] decode(input logic [5:0] rn);
    logic [63:0] d;
    d     = '0;
    d[rn] = 1'b1;
    d[0]  = 1'b0;
    return d;
  endfunction

  logic [63:0] regs [63:1];
  logic [63:0] busy;
  logic [63:0] busy_nxt;
  logic [63:0] set_mask;
  logic [63:0] clr_mask;
  logic [63:0] src_mask;
  logic [63:0] eff_busy;
  logic        hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 64; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else if (bus.write_rn != 6'd0) begin
      regs[bus.write_rn] <= bus.write_data;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [5:0]  addr;
    logic [63:0] stored;
    assign addr   = bus.rd_addr[6*k +: 6];
    assign stored = (addr == 6'd0) ? 64'd0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
    assign bus.rd_data[64*k +: 64] = (addr != 6'd0 && addr == bus.write_rn) ? bus.write_data : stored;
`else
    assign bus.rd_data[64*k +: 64] = stored;
`endif
  end

  assign set_mask = bus.issue_fire ? (decode(bus.issue_rd1) | decode(bus.issue_rd2)) : 64'd0;
  assign clr_mask = decode(bus.write_rn);

  // A new owner marked on the same edge as the old owner's commit stays busy.
  always_comb begin
    busy_nxt = '0;
    if (!bus.flush) begin
      busy_nxt = (busy & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_comb begin
    src_mask = decode(bus.issue_rd1) | decode(bus.issue_rd2);
    for (int k = 0; k < NREAD; k++) begin
      src_mask = src_mask | decode(bus.issue_rs[6*k +: 6]);
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign eff_busy = busy & ~clr_mask;
`else
  assign eff_busy = busy;
`endif

  assign hazard          = |(eff_busy & src_mask);
  assign bus.issue_stall = bus.issue_valid & hazard;
  assign bus.issue_fire  = bus.issue_valid & ~hazard;
  assign bus.busy_vec    = busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard
`timescale 1ns/1ps
module tb_regfile_scoreboard;
  localparam int          NREAD = 4;
  localparam logic [63:0] RV    = 64'hA5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.NREAD(NREAD)) bus ();
  regfile_scoreboard #(.NREAD(NREAD), .RESET_VALUE(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] m_regs [64];
  logic [63:0] m_busy;
  logic [63:0] exp_q [$];

  task automatic idle();
    bus.write_rn    = '0;
    bus.write_data  = '0;
    bus.rd_addr     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rs    = '0;
    bus.issue_rd1   = '0;
    bus.issue_rd2   = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic model_reset();
    m_regs[0] = 64'd0;
    for (int i = 1; i < 64; i++) m_regs[i] = RV;
    m_busy = 64'd0;
  endtask

  function automatic logic model_stall();
    logic [63:0] eb;
    logic        hit;
    eb = m_busy;
`ifdef REGFILE_BYPASS_EN
    if (bus.write_rn != 6'd0) eb[bus.write_rn] = 1'b0;
`endif
    hit = 1'b0;
    for (int k = 0; k < NREAD; k++) begin
      if (bus.issue_rs[6*k +: 6] != 6'd0 && eb[bus.issue_rs[6*k +: 6]]) hit = 1'b1;
    end
    if (bus.issue_rd1 != 6'd0 && eb[bus.issue_rd1]) hit = 1'b1;
    if (bus.issue_rd2 != 6'd0 && eb[bus.issue_rd2]) hit = 1'b1;
    return bus.issue_valid && hit;
  endfunction

  // Advance one clock, applying the driven inputs to the reference model.
  task automatic step();
    logic fire;
    fire = bus.issue_valid && !model_stall();
    @(posedge clk);
    if (bus.write_rn != 6'd0) m_regs[bus.write_rn] = bus.write_data;
    if (bus.flush) begin
      m_busy = 64'd0;
    end else begin
      if (bus.write_rn != 6'd0) m_busy[bus.write_rn] = 1'b0;
      if (fire) begin
        if (bus.issue_rd1 != 6'd0) m_busy[bus.issue_rd1] = 1'b1;
        if (bus.issue_rd2 != 6'd0) m_busy[bus.issue_rd2] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic present_reads(input logic [6*NREAD-1:0] addrs);
    bus.rd_addr = addrs;
    for (int k = 0; k < NREAD; k++) exp_q.push_back(m_regs[addrs[6*k +: 6]]);
  endtask

  task automatic test_reset();
    logic [63:0] got, exp;
    idle();
    rst = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_rs[5:0] = 6'd5;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (bus.busy_vec !== 64'd0) begin errors++; $display("FAIL reset_busy: got %h expected 0", bus.busy_vec); end
    checks++;
    if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.issue_stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    present_reads({6'd1, 6'd63, 6'd0, 6'd5});
    #1;
    checks++;
    if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL reset_fire: got %b expected 1", bus.issue_fire); end
    for (int k = 0; k < NREAD; k++) begin
      got = bus.rd_data[64*k +: 64];
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_read port%0d: got %h expected %h", k, got, exp); end
    end
    idle();
  endtask

  task automatic test_raw();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd1 = 6'd7;
    #1;
    checks++;
    if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL raw_mark_fire: got %b expected 1", bus.issue_fire); end
    step();
    idle();
    checks++;
    if (bus.busy_vec !== (64'd1 << 7)) begin errors++; $display("FAIL raw_busy7: got %h expected %h", bus.busy_vec, 64'd1 << 7); end
    bus.issue_valid = 1'b1;
    bus.issue_rs[5:0] = 6'd7;
    bus.rd_addr[5:0] = 6'd7;
    #1;
    checks++;
    if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b expected 1", bus.issue_stall); end
    step();
    checks++;
    if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_hold: got %b expected 1", bus.issue_stall); end
    bus.write_rn = 6'd7;
    bus.write_data = 64'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL raw_commit_stall: got %b expected 0", bus.issue_stall); end
    checks++;
    if (bus.rd_data[63:0] !== 64'h1234) begin errors++; $display("FAIL raw_bypass_read: got %h expected 1234", bus.rd_data[63:0]); end
`else
    checks++;
    if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL raw_commit_stall: got %b expected 1", bus.issue_stall); end
    checks++;
    if (bus.rd_data[63:0] !== RV) begin errors++; $display("FAIL raw_commit_read: got %h expected %h", bus.rd_data[63:0], RV); end
`endif
    step();
    bus.write_rn = 6'd0;
    #1;
    checks++;
    if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL raw_after_commit_stall: got %b expected 0", bus.issue_stall); end
    checks++;
    if (bus.rd_data[63:0] !== 64'h1234) begin errors++; $display("FAIL raw_after_commit_read: got %h expected 1234", bus.rd_data[63:0]); end
    checks++;
    if (bus.busy_vec !== m_busy) begin errors++; $display("FAIL raw_busy_clear: got %h expected %h", bus.busy_vec, m_busy); end
    idle();
  endtask

  task automatic test_waw();
    logic [63:0] saved;
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd1 = 6'd9;
    step();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd2 = 6'd9;
    #1;
    checks++;
    if (bus.issue_stall !== 1'b1 || bus.issue_fire !== 1'b0)
      begin errors++; $display("FAIL waw_stall: got stall=%b fire=%b expected stall=1 fire=0", bus.issue_stall, bus.issue_fire); end
    bus.issue_rd2 = 6'd0;
    #1;
    checks++;
    if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL waw_nodest_fire: got %b expected 1", bus.issue_fire); end
    saved = m_busy;
    step();
    idle();
    checks++;
    if (bus.busy_vec !== saved) begin errors++; $display("FAIL waw_nodest_busy: got %h expected %h", bus.busy_vec, saved); end
    bus.write_rn = 6'd9;
    bus.write_data = 64'hDEAD_0009;
    step();
    idle();
    #1;
    checks++;
    if (bus.busy_vec[9] !== 1'b0) begin errors++; $display("FAIL waw_commit9: got %b expected 0", bus.busy_vec[9]); end
  endtask

  task automatic test_same_edge();
    logic [63:0] got, exp;
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd1 = 6'd12;
    bus.write_rn = 6'd12;
    bus.write_data = 64'h0000_1200_0000_0001;
    #1;
    checks++;
    if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL same_edge_idle_fire: got %b expected 1", bus.issue_fire); end
    step();
    idle();
    #1;
    checks++;
    if (bus.busy_vec[12] !== 1'b1) begin errors++; $display("FAIL same_edge_set_wins: got %b expected 1", bus.busy_vec[12]); end
    bus.issue_valid = 1'b1;
    bus.issue_rd1 = 6'd12;
    bus.write_rn = 6'd12;
    bus.write_data = 64'h0000_1200_0000_0002;
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (bus.issue_fire !== 1'b1) begin errors++; $display("FAIL same_edge_busy_fire: got %b expected 1", bus.issue_fire); end
`else
    if (bus.issue_fire !== 1'b0) begin errors++; $display("FAIL same_edge_busy_fire: got %b expected 0", bus.issue_fire); end
`endif
    step();
    idle();
    present_reads({6'd0, 6'd0, 6'd12, 6'd12});
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (bus.busy_vec[12] !== 1'b1) begin errors++; $display("FAIL same_edge_busy12: got %b expected 1", bus.busy_vec[12]); end
`else
    if (bus.busy_vec[12] !== 1'b0) begin errors++; $display("FAIL same_edge_busy12: got %b expected 0", bus.busy_vec[12]); end
`endif
    for (int k = 0; k < NREAD; k++) begin
      got = bus.rd_data[64*k +: 64];
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL same_edge_read port%0d: got %h expected %h", k, got, exp); end
    end
    idle();
    if (m_busy[12]) begin
      bus.write_rn = 6'd12;
      bus.write_data = 64'h0000_1200_0000_0002;
      step();
      idle();
    end
  endtask

  task automatic test_advint();
    logic [63:0] got, exp;
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd1 = 6'd3;
    bus.issue_rd2 = 6'd4;
    step();
    idle();
    #1;
    checks++;
    if (bus.busy_vec !== ((64'd1 << 3) | (64'd1 << 4))) begin errors++; $display("FAIL advint_both_busy: got %h expected %h", bus.busy_vec, (64'd1 << 3) | (64'd1 << 4)); end
    bus.write_rn = 6'd4;
    bus.write_data = 64'h4444;
    step();
    bus.write_rn = 6'd3;
    bus.write_data = 64'h3333;
    #1;
    checks++;
    if (bus.busy_vec[4:3] !== 2'b01) begin errors++; $display("FAIL advint_clear4: got %b expected 01", bus.busy_vec[4:3]); end
    step();
    idle();
    #1;
    checks++;
    if (bus.busy_vec[4:3] !== 2'b00) begin errors++; $display("FAIL advint_clear3: got %b expected 00", bus.busy_vec[4:3]); end
    bus.issue_valid = 1'b1;
    bus.issue_rd1 = 6'd20;
    bus.issue_rd2 = 6'd20;
    step();
    idle();
    present_reads({6'd0, 6'd20, 6'd4, 6'd3});
    #1;
    checks++;
    if (bus.busy_vec !== (64'd1 << 20)) begin errors++; $display("FAIL advint_same_dest: got %h expected %h", bus.busy_vec, 64'd1 << 20); end
    for (int k = 0; k < NREAD; k++) begin
      got = bus.rd_data[64*k +: 64];
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL advint_read port%0d: got %h expected %h", k, got, exp); end
    end
    idle();
    bus.write_rn = 6'd20;
    bus.write_data = 64'h2020;
    step();
    idle();
  endtask

  task automatic test_flush();
    logic [63:0] got, exp;
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd1 = 6'd3;
    bus.issue_rd2 = 6'd4;
    step();
    bus.issue_rd1 = 6'd63;
    bus.issue_rd2 = 6'd0;
    step();
    idle();
    #1;
    checks++;
    if (bus.busy_vec !== ((64'd1 << 3) | (64'd1 << 4) | (64'd1 << 63)))
      begin errors++; $display("FAIL flush_pre_busy: got %h expected %h", bus.busy_vec, (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 63)); end
    bus.flush = 1'b1;
    bus.write_rn = 6'd63;
    bus.write_data = 64'hFEED_FACE_0000_0063;
    bus.issue_valid = 1'b1;
    bus.issue_rd1 = 6'd5;
    step();
    idle();
    present_reads({6'd3, 6'd4, 6'd5, 6'd63});
    #1;
    checks++;
    if (bus.busy_vec !== 64'd0) begin errors++; $display("FAIL flush_busy: got %h expected 0", bus.busy_vec); end
    for (int k = 0; k < NREAD; k++) begin
      got = bus.rd_data[64*k +: 64];
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL flush_read port%0d: got %h expected %h", k, got, exp); end
    end
    checks++;
    if (bus.rd_data[63:0] !== 64'hFEED_FACE_0000_0063) begin errors++; $display("FAIL flush_r63: got %h expected feedface00000063", bus.rd_data[63:0]); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [5:0]  wr_rn [12];
    logic [63:0] got, exp;
    idle();
    for (int i = 0; i < 12; i++) begin
      wr_rn[i] = 6'($urandom_range(63, 1));
      bus.write_rn = wr_rn[i];
      bus.write_data = {$urandom, $urandom};
      step();
    end
    idle();
    for (int b = 0; b < 3; b++) begin
      present_reads({wr_rn[4*b+3], wr_rn[4*b+2], wr_rn[4*b+1], wr_rn[4*b]});
      #1;
      for (int k = 0; k < NREAD; k++) begin
        got = bus.rd_data[64*k +: 64];
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL b2b_read batch%0d port%0d: got %h expected %h", b, k, got, exp); end
      end
    end
    checks++;
    if (bus.busy_vec !== 64'd0) begin errors++; $display("FAIL b2b_busy: got %h expected 0", bus.busy_vec); end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [63:0] got, exp;
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd1 = 6'd10;
    bus.issue_rd2 = 6'd11;
    bus.write_rn = 6'd40;
    bus.write_data = 64'h4040_4040;
    step();
    bus.issue_rd1 = 6'd0;
    bus.issue_rd2 = 6'd0;
    bus.issue_rs[5:0] = 6'd10;
    bus.write_rn = 6'd41;
    bus.write_data = 64'h4141_4141;
    #1;
    rst = 1'b1;
    model_reset();
    present_reads({6'd0, 6'd10, 6'd41, 6'd40});
    #1;
    checks++;
    if (bus.busy_vec !== 64'd0) begin errors++; $display("FAIL reset_mid_busy: got %h expected 0", bus.busy_vec); end
    checks++;
    if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL reset_mid_stall: got %b expected 0", bus.issue_stall); end
    for (int k = 0; k < NREAD; k++) begin
      got = bus.rd_data[64*k +: 64];
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_mid_read port%0d: got %h expected %h", k, got, exp); end
    end
    @(posedge clk); #1;
    idle();
    rst = 1'b0;
    step();
    present_reads({6'd0, 6'd0, 6'd41, 6'd40});
    #1;
    for (int k = 0; k < NREAD; k++) begin
      got = bus.rd_data[64*k +: 64];
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_mid_lost_write port%0d: got %h expected %h", k, got, exp); end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_raw();
    test_waw();
    test_same_edge();
    test_advint();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Architectural integer register file plus per-register busy scoreboard; the receiving end of the commit unit's single write port (write_rn/write_data).
- Supplies operands to the issue stage.
- Issue marks destination registers busy. Commit writes clear them.
- Issue stalls on RAW/WAW hazards against in-flight destinations.

Parameters:
- NREAD, 4, number of combinational read ports (1..8).
- RESET_VALUE, 64'h0, value loaded into r1..r63 on reset.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- write_rn  input  6  commit destination; 0 = no write this cycle
- write_data  input  64  commit data
- rd_addr  input  6*NREAD  read addresses, port k at [6k+5:6k]
- rd_data  output  64*NREAD  read data, port k at [64k+63:64k]
- issue_valid  input  1  issue stage presents an instruction
- issue_rs  input  6*NREAD  source registers of presented instruction (0 = unused)
- issue_rd1  input  6  first destination (0 = none)
- issue_rd2  input  6  second destination, advint pair (0 = none)
- issue_stall  output  1  instruction may not issue this cycle
- issue_fire  output  1  issue_valid & ~issue_stall
- flush  input  1  synchronous clear of all busy bits
- busy_vec  output  64  current busy bits, bit n = rn

Behaviour:
- Storage: r0..r63, 64 bits each.
  - r0 reads 0 always and is never written or marked busy.
  - r63 is the branch link/PC target written by commit; it is an ordinary register here.
- Reset (rst high, asynchronous): r1..r63 = RESET_VALUE; busy_vec = 0; issue_stall = 0 (combinational, so 0 once busy clears); rd_data reflects reset contents.
- Write:
  - On the rising edge with write_rn != 0, reg[write_rn] <= write_data.
  - Single write per cycle.
  - Commit drives write_rn = 0 when idle.
- Read:
  - Combinational, zero latency.
  - rd_data[k] = 0 if rd_addr[k] == 0.
  - Otherwise the stored value, subject to the bypass rule under Optional Feature.
- Scoreboard, per register n != 0, next-state priority:
  - flush → 0.
  - issue_fire with issue_rd1 == n or issue_rd2 == n → 1.
  - write_rn == n → 0.
  - otherwise hold.
  - Set beats clear when both hit the same register in the same edge; the commit write completes, the new owner stays busy.
- Effective busy, eff_busy(n): busy_vec[n], masked per the Optional Feature rule. r0 is never busy.
- issue_stall = issue_valid & (any nonzero issue_rs[k] with eff_busy, or nonzero issue_rd1/issue_rd2 with eff_busy).
  - Covers RAW and WAW.
  - When issue_valid is 0, issue_stall is 0.
- Dual destination:
  - issue_rd1 == issue_rd2 != 0 sets a single bit.
  - Both destinations are checked independently.
- Latency: a register marked at edge T is busy from T onward. A commit at edge T' clears it after T'.
- Flush:
  - Clears busy only; register contents are unchanged.
  - A same-edge write still lands.
  - A same-edge issue_fire does not set busy.
- Reset mid-operation: all state returns to reset values asynchronously; pending writes are lost.
- Width rule: no arithmetic. All addresses are 6-bit unsigned. NREAD out of range is a synthesis-time error.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle write-through: rd_data[k] = write_data when rd_addr[k] == write_rn != 0.
  - eff_busy(n) = busy_vec[n] & ~(write_rn == n), so an instruction waiting on the committing register issues in the commit cycle.
- Undefined:
  - rd_data always comes from storage.
  - eff_busy(n) = busy_vec[n].
  - A dependent instruction issues one cycle after the commit edge.
  - Removes the write_data → rd_data and write_rn → issue_stall combinational paths.

Test Plan:
- Reset, then read r5 and r0 with RESET_VALUE=64'hA5 → rd_data r5 = 64'hA5, r0 = 0, busy_vec = 0, issue_stall = 0.
- Issue rd1 = 7 → busy_vec[7] = 1 next cycle. Then issue rs = 7 → issue_stall = 1 until commit write_rn = 7, write_data = 64'h1234. With REGFILE_BYPASS_EN, stall drops in the commit cycle and rd_data = 64'h1234 that cycle; without it, stall drops the cycle after.
- WAW: r9 busy, issue rd2 = 9 → issue_stall = 1. Issue rd1 = 0, rd2 = 0 with rs = 0 → issue_fire = 1, busy_vec unchanged.
- Same edge: commit write_rn = 12 while issue_fire with rd1 = 12 (bypass on, r12 busy) → reg[12] = written data, busy_vec[12] = 1 after the edge.
- Advint pair: issue rd1 = 3, rd2 = 4 → both busy. Commit 4 then 3 on consecutive cycles → bits clear in that order.
- flush with busy r3, r4, r63 and simultaneous write_rn = 63 → busy_vec = 0, r63 updated. Assert rst mid-stream → busy_vec = 0 and registers = RESET_VALUE immediately, without a clock edge.
